// File: rtl/ucie_rdi_pkg.sv
// ---------------------------------------------------------------------------
// ucie_rdi_pkg
// Shared definitions for the RDI transmit arbitration logic.
//   rdi_arb_state_e : arbiter FSM state encoding
//   RDI_EMPTY_W     : width of the per-beat empty-byte count
//   RDI_MAX_REQ     : largest supported requester count
// ---------------------------------------------------------------------------
package ucie_rdi_pkg;

    localparam int RDI_EMPTY_W = 6;
    localparam int RDI_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STALL = 2'd2
    } rdi_arb_state_e;

endpackage : ucie_rdi_pkg

// File: rtl/ucie_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ucie_rr_arbiter
// Combinational round-robin picker. The search starts at last_grant+1
// (modulo NUM_REQ) and returns the first eligible index.
//   eligible    in  NUM_REQ : candidate vector
//   last_grant  in  IDX_W   : index of the previous winner
//   grant_valid out 1       : at least one candidate is eligible
//   grant_idx   out IDX_W   : winning index (0 when grant_valid=0)
// ---------------------------------------------------------------------------
module ucie_rr_arbiter
    import ucie_rdi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // Walk from the farthest offset down to the nearest so that the
        // closest eligible requester after last_grant is the final write.
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule : ucie_rr_arbiter

// File: rtl/ucie_rdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ucie_rdi_tx_arbiter
// Packet-atomic round-robin arbiter sharing one RDI transmit channel among
// NUM_REQ requesters, plus the transmit side of the stall handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; arbitrate sop beats, or park on pl_stallreq
//   XFER  | grant_id owns the channel until its eop beat transfers
//   STALL | channel parked; lp_stallack held while pl_stallreq stays high
//
// Ports:
//   clk, resetn                     : clock, async active-low reset
//   req_valid/sop/eop   in NUM_REQ  : per-requester beat qualifiers
//   req_data  in NUM_REQ*DATA_WIDTH : requester i at slice i
//   req_user  in NUM_REQ*USER_WIDTH : requester i at slice i
//   req_empty in NUM_REQ*6          : requester i at slice i
//   req_ready out NUM_REQ           : beat accept, only for the owner
//   tx_valid/data/user/sop/eop/empty: RDI transmit beat (muxed owner)
//   tx_ready  in 1                  : RDI transmit accept
//   pl_stallreq in 1, lp_stallack out 1 : stall handshake
//   grant_id  out                   : current owner, meaningful in XFER
//   sop_err   out 1                 : pulse on a new sop-less beat in IDLE
// ---------------------------------------------------------------------------
module ucie_rdi_tx_arbiter
    import ucie_rdi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 16,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*USER_WIDTH-1:0]     req_user,
    input  logic [NUM_REQ-1:0]                req_sop,
    input  logic [NUM_REQ-1:0]                req_eop,
    input  logic [NUM_REQ*RDI_EMPTY_W-1:0]    req_empty,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              tx_valid,
    output logic [DATA_WIDTH-1:0]             tx_data,
    output logic [USER_WIDTH-1:0]             tx_user,
    output logic                              tx_sop,
    output logic                              tx_eop,
    output logic [RDI_EMPTY_W-1:0]            tx_empty,
    input  logic                              tx_ready,
    input  logic                              pl_stallreq,
    output logic                              lp_stallack,
    output logic [IDX_W-1:0]                  grant_id,
    output logic                              sop_err
);

    rdi_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             stallack_q, stallack_d;
    logic [NUM_REQ-1:0] bad_q, bad_d;
    logic             sop_err_q, sop_err_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             in_xfer;
    logic             eop_fire;

    logic [DATA_WIDTH-1:0]  data_arr  [NUM_REQ];
    logic [USER_WIDTH-1:0]  user_arr  [NUM_REQ];
    logic [RDI_EMPTY_W-1:0] empty_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g]  = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign user_arr[g]  = req_user[g*USER_WIDTH +: USER_WIDTH];
        assign empty_arr[g] = req_empty[g*RDI_EMPTY_W +: RDI_EMPTY_W];
    end

    // Only sop beats may open a packet; sop-less beats are held off in IDLE.
    ucie_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .eligible    (req_valid & req_sop),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign in_xfer  = (state_q == XFER);
    assign eop_fire = in_xfer & req_valid[grant_q] & tx_ready & req_eop[grant_q];

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_user   = '0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        tx_empty  = '0;
        req_ready = '0;
        if (in_xfer) begin
            tx_valid           = req_valid[grant_q];
            tx_data            = data_arr[grant_q];
            tx_user            = user_arr[grant_q];
            tx_sop             = req_sop[grant_q];
            tx_eop             = req_eop[grant_q];
            tx_empty           = empty_arr[grant_q];
            req_ready[grant_q] = tx_ready;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (pl_stallreq) begin
                    state_d = STALL;
                end else if (pick_valid) begin
                    state_d      = XFER;
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                end
            end
            XFER: begin
                if (eop_fire) begin
                    state_d = pl_stallreq ? STALL : IDLE;
                end
            end
            STALL: begin
                if (!pl_stallreq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The acknowledge is registered, so it appears on the second STALL cycle
    // and drops the cycle after pl_stallreq is seen low.
    assign stallack_d = (state_q == STALL) & pl_stallreq;

    // One pulse per offending run: flag only requesters that were not
    // already offending on the previous cycle.
    assign bad_d     = (state_q == IDLE) ? (req_valid & ~req_sop) : '0;
    assign sop_err_d = |(bad_d & ~bad_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            stallack_q   <= 1'b0;
            bad_q        <= '0;
            sop_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stallack_q   <= stallack_d;
            bad_q        <= bad_d;
            sop_err_q    <= sop_err_d;
        end
    end

    assign lp_stallack = stallack_q;
    assign grant_id    = grant_q;
    assign sop_err     = sop_err_q;

endmodule : ucie_rdi_tx_arbiter

// File: tb/tb_ucie_rdi_tx_arbiter.sv
module tb_ucie_rdi_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int EW = 6;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_valid, req_sop, req_eop, req_ready;
    logic [N*DW-1:0] req_data;
    logic [N*UW-1:0] req_user;
    logic [N*EW-1:0] req_empty;
    logic            tx_valid, tx_sop, tx_eop, tx_ready;
    logic [DW-1:0]   tx_data;
    logic [UW-1:0]   tx_user;
    logic [EW-1:0]   tx_empty;
    logic            pl_stallreq, lp_stallack, sop_err;
    logic [1:0]      grant_id;

    int vectors     = 0;
    int miscompares = 0;
    int exp_g [5]   = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    ucie_rdi_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_user    (req_user),
        .req_sop     (req_sop),
        .req_eop     (req_eop),
        .req_empty   (req_empty),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_user     (tx_user),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_empty    (tx_empty),
        .tx_ready    (tx_ready),
        .pl_stallreq (pl_stallreq),
        .lp_stallack (lp_stallack),
        .grant_id    (grant_id),
        .sop_err     (sop_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // user = 0xC0 | requester, empty = low 6 bits of data
    task automatic drive(input int i, input logic v, input logic s, input logic e,
                         input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_sop[i]             = s;
        req_eop[i]             = e;
        req_data[i*DW +: DW]   = d;
        req_user[i*UW +: UW]   = 8'hC0 | 8'(i);
        req_empty[i*EW +: EW]  = d[5:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        resetn      = 1'b0;
        req_valid   = '0;
        req_sop     = '0;
        req_eop     = '0;
        req_data    = '0;
        req_user    = '0;
        req_empty   = '0;
        tx_ready    = 1'b0;
        pl_stallreq = 1'b0;

        // ---- reset: outputs 0 even with a request pending
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0);
        tx_ready = 1'b1;
        #3;
        chk("rst_txv",   64'(tx_valid),    64'h0);
        chk("rst_rdy",   64'(req_ready),   64'h0);
        chk("rst_ack",   64'(lp_stallack), 64'h0);
        chk("rst_gid",   64'(grant_id),    64'h0);
        chk("rst_serr",  64'(sop_err),     64'h0);
        repeat (2) @(posedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // ---- two 3-beat packets, req0 then req2
        drive(0, 1'b1, 1'b1, 1'b0, 32'h000);
        drive(2, 1'b1, 1'b1, 1'b0, 32'h200);
        #1 chk("t1_idle_txv", 64'(tx_valid), 64'h0);
        tick(); #1;
        chk("t1_gid0",  64'(grant_id),  64'h0);
        chk("t1_txv",   64'(tx_valid),  64'h1);
        chk("t1_d0",    64'(tx_data),   64'h000);
        chk("t1_sop",   64'(tx_sop),    64'h1);
        chk("t1_rdy0",  64'(req_ready), 64'b0001);
        tick(); drive(0, 1'b1, 1'b0, 1'b0, 32'h001); #1;
        chk("t1_d1",    64'(tx_data),   64'h001);
        chk("t1_sop1",  64'(tx_sop),    64'h0);
        tick(); drive(0, 1'b1, 1'b0, 1'b1, 32'h002); #1;
        chk("t1_d2",    64'(tx_data),   64'h002);
        chk("t1_eop",   64'(tx_eop),    64'h1);
        chk("t1_user",  64'(tx_user),   64'hC0);
        chk("t1_empty", 64'(tx_empty),  64'h02);
        tick(); drive(0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
        chk("t1_bubble_txv", 64'(tx_valid),  64'h0);
        chk("t1_bubble_rdy", 64'(req_ready), 64'h0);
        tick(); #1;
        chk("t1_gid2",  64'(grant_id),  64'h2);
        chk("t1_d200",  64'(tx_data),   64'h200);
        chk("t1_rdy2",  64'(req_ready), 64'b0100);
        tick(); drive(2, 1'b1, 1'b0, 1'b0, 32'h201); #1;
        chk("t1_d201",  64'(tx_data),   64'h201);
        tick(); drive(2, 1'b1, 1'b0, 1'b1, 32'h202); #1;
        chk("t1_d202",  64'(tx_data),   64'h202);
        chk("t1_user2", 64'(tx_user),   64'hC2);
        tick(); drive(2, 1'b0, 1'b0, 1'b0, 32'h0); #1;
        chk("t1_end_txv", 64'(tx_valid), 64'h0);

        // ---- reset mid-packet on req3, then req0 beats req3
        drive(3, 1'b1, 1'b1, 1'b0, 32'h300);
        tick(); #1;
        chk("t6_gid3", 64'(grant_id), 64'h3);
        chk("t6_d300", 64'(tx_data),  64'h300);
        tick(); drive(3, 1'b1, 1'b0, 1'b0, 32'h301); #1;
        chk("t6_d301", 64'(tx_data),  64'h301);
        resetn = 1'b0;
        #1;
        chk("t6_rst_txv",  64'(tx_valid),  64'h0);
        chk("t6_rst_rdy",  64'(req_ready), 64'h0);
        chk("t6_rst_gid",  64'(grant_id),  64'h0);
        chk("t6_rst_data", 64'(tx_data),   64'h0);
        drive(3, 1'b1, 1'b1, 1'b1, 32'h310);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h010);
        @(negedge clk);
        resetn = 1'b1;
        tick(); #1;
        chk("t6_win0",  64'(grant_id), 64'h0);
        chk("t6_d010",  64'(tx_data),  64'h010);
        tick(); drive(0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
        chk("t6_bubble", 64'(tx_valid), 64'h0);
        tick(); #1;
        chk("t6_then3", 64'(grant_id), 64'h3);
        chk("t6_d310",  64'(tx_data),  64'h310);
        tick(); drive(3, 1'b0, 1'b0, 1'b0, 32'h0); #1;

        // ---- all four offer 1-beat packets continuously
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 1'b1, 32'(i) << 8);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk($sformatf("t2_gid_%0d", k), 64'(grant_id), 64'(exp_g[k]));
            chk($sformatf("t2_dat_%0d", k), 64'(tx_data),  64'(exp_g[k] << 8));
            tick(); if (k == 4) for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 1'b0, 32'h0);
            #1 chk($sformatf("t2_bub_%0d", k), 64'(tx_valid), 64'h0);
        end

        // ---- stall raised during beat 2 of a 4-beat packet
        drive(1, 1'b1, 1'b1, 1'b0, 32'h110);
        tick(); #1;
        chk("t3_gid1", 64'(grant_id),    64'h1);
        chk("t3_d0",   64'(tx_data),     64'h110);
        tick(); drive(1, 1'b1, 1'b0, 1'b0, 32'h111); pl_stallreq = 1'b1; #1;
        chk("t3_d1",   64'(tx_data),     64'h111);
        tick(); drive(1, 1'b1, 1'b0, 1'b0, 32'h112); #1;
        chk("t3_d2",   64'(tx_data),     64'h112);
        chk("t3_ack_mid", 64'(lp_stallack), 64'h0);
        tick(); drive(1, 1'b1, 1'b0, 1'b1, 32'h113); #1;
        chk("t3_d3",   64'(tx_data),     64'h113);
        chk("t3_eop",  64'(tx_eop),      64'h1);
        tick(); drive(1, 1'b1, 1'b1, 1'b1, 32'h120); #1;
        chk("t3_st_txv", 64'(tx_valid),    64'h0);
        chk("t3_st_rdy", 64'(req_ready),   64'h0);
        chk("t3_st_ack0", 64'(lp_stallack), 64'h0);
        tick(); #1;
        chk("t3_st_ack1", 64'(lp_stallack), 64'h1);
        chk("t3_st_txv2", 64'(tx_valid),    64'h0);
        pl_stallreq = 1'b0;
        tick(); #1;
        chk("t3_ack_fall", 64'(lp_stallack), 64'h0);
        chk("t3_idle_txv", 64'(tx_valid),    64'h0);
        tick(); #1;
        chk("t3_resume_txv", 64'(tx_valid), 64'h1);
        chk("t3_resume_d",   64'(tx_data),  64'h120);
        tick(); drive(1, 1'b0, 1'b0, 1'b0, 32'h0); #1;

        // ---- tx_ready toggling 1,0,1,0,1 over a 3-beat packet
        drive(2, 1'b1, 1'b1, 1'b0, 32'h220);
        tick(); tx_ready = 1'b1; #1;
        chk("t4_d0",   64'(tx_data),   64'h220);
        chk("t4_r0",   64'(req_ready), 64'b0100);
        tick(); drive(2, 1'b1, 1'b0, 1'b0, 32'h221); tx_ready = 1'b0; #1;
        chk("t4_d1a",  64'(tx_data),   64'h221);
        chk("t4_r1a",  64'(req_ready), 64'b0000);
        chk("t4_v1a",  64'(tx_valid),  64'h1);
        tick(); tx_ready = 1'b1; #1;
        chk("t4_d1b",  64'(tx_data),   64'h221);
        chk("t4_r1b",  64'(req_ready), 64'b0100);
        tick(); drive(2, 1'b1, 1'b0, 1'b1, 32'h222); tx_ready = 1'b0; #1;
        chk("t4_d2a",  64'(tx_data),   64'h222);
        chk("t4_r2a",  64'(req_ready), 64'b0000);
        tick(); tx_ready = 1'b1; #1;
        chk("t4_d2b",  64'(tx_data),   64'h222);
        chk("t4_eop",  64'(tx_eop),    64'h1);
        chk("t4_r2b",  64'(req_ready), 64'b0100);
        tick(); drive(2, 1'b0, 1'b0, 1'b0, 32'h0); #1;
        chk("t4_done1", 64'(tx_valid), 64'h0);
        tick(); #1;
        chk("t4_done2", 64'(tx_valid), 64'h0);

        // ---- sop-less beat in IDLE
        drive(1, 1'b1, 1'b0, 1'b0, 32'h1EE);
        #1;
        chk("t5_serr_c0", 64'(sop_err),  64'h0);
        chk("t5_txv_c0",  64'(tx_valid), 64'h0);
        tick(); #1;
        chk("t5_serr_c1", 64'(sop_err),   64'h1);
        chk("t5_rdy_c1",  64'(req_ready), 64'h0);
        chk("t5_txv_c1",  64'(tx_valid),  64'h0);
        tick(); #1;
        chk("t5_serr_c2", 64'(sop_err),   64'h0);
        chk("t5_txv_c2",  64'(tx_valid),  64'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ucie_rdi_tx_arbiter
